// File: rtl/serial_cmp_pkg.sv
// Shared types and helpers for the digit-serial magnitude comparator.
// State encoding, counter sizing and the packed compare-result record.
package serial_cmp_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_e;

  typedef struct packed {
    logic lt;
    logic ltu;
    logic eq;
  } cmp_result_t;

  // Bits needed to count digit indices 0..ndig-1, never fewer than one.
  function automatic int cnt_width(input int ndig);
    int w;
    w = 1;
    while ((1 << w) < ndig) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/digit_compare.sv
// Combinational unsigned compare of one DIGIT-wide slice of each operand.
module digit_compare #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] da,
  input  logic [DIGIT-1:0] db,
  output logic             dlt,
  output logic             deq
);

  // Unsigned less-than and equality of the current digit pair.
  always_comb begin
    dlt = (da < db);
    deq = (da == db);
  end

endmodule

// File: rtl/serial_magnitude_comparator.sv
// Digit-serial, MSB-first magnitude comparator with start/busy/done handshake.
// Optional SERIAL_CMP_MINMAX_EN adds mode_signed input and min/max outputs.
module serial_magnitude_comparator
  import serial_cmp_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SERIAL_CMP_MINMAX_EN
  input  logic             mode_signed,
  output logic [WIDTH-1:0] min,
  output logic [WIDTH-1:0] max,
`endif
  output logic             busy,
  output logic             done,
  output logic             lt,
  output logic             ltu,
  output logic             eq
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = cnt_width(NDIG);
  localparam logic [CW-1:0] CNT_LAST = CW'(NDIG - 1);

  if ((WIDTH < 2) || (DIGIT < 1) || (DIGIT > WIDTH) || ((WIDTH % DIGIT) != 0)) begin : g_bad_params
    $fatal(1, "serial_magnitude_comparator: WIDTH must be >= 2 and a multiple of DIGIT (1 <= DIGIT <= WIDTH)");
  end

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             sign_diff_q, sign_diff_d;
  logic             a_neg_q, a_neg_d;
  logic             done_q, done_d;
  cmp_result_t      res_q, res_d;
  logic             dig_lt, dig_eq;

`ifdef SERIAL_CMP_MINMAX_EN
  logic [WIDTH-1:0] a_cap_q, a_cap_d;
  logic [WIDTH-1:0] b_cap_q, b_cap_d;
  logic             msgn_q, msgn_d;
  logic [WIDTH-1:0] min_q, min_d;
  logic [WIDTH-1:0] max_q, max_d;
  logic             a_first;
`endif

  digit_compare #(.DIGIT(DIGIT)) u_digit_compare (
    .da  (a_sh_q[WIDTH-1 -: DIGIT]),
    .db  (b_sh_q[WIDTH-1 -: DIGIT]),
    .dlt (dig_lt),
    .deq (dig_eq)
  );

  // State and datapath registers; reset abandons any compare in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      cnt_q       <= '0;
      sign_diff_q <= 1'b0;
      a_neg_q     <= 1'b0;
      done_q      <= 1'b0;
      res_q       <= '0;
`ifdef SERIAL_CMP_MINMAX_EN
      a_cap_q     <= '0;
      b_cap_q     <= '0;
      msgn_q      <= 1'b0;
      min_q       <= '0;
      max_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      a_sh_q      <= a_sh_d;
      b_sh_q      <= b_sh_d;
      cnt_q       <= cnt_d;
      sign_diff_q <= sign_diff_d;
      a_neg_q     <= a_neg_d;
      done_q      <= done_d;
      res_q       <= res_d;
`ifdef SERIAL_CMP_MINMAX_EN
      a_cap_q     <= a_cap_d;
      b_cap_q     <= b_cap_d;
      msgn_q      <= msgn_d;
      min_q       <= min_d;
      max_q       <= max_d;
`endif
    end
  end

  // Next-state: capture on start, then scan digits until the first difference.
  always_comb begin
    state_d     = state_q;
    a_sh_d      = a_sh_q;
    b_sh_d      = b_sh_q;
    cnt_d       = cnt_q;
    sign_diff_d = sign_diff_q;
    a_neg_d     = a_neg_q;
    done_d      = 1'b0;
    res_d       = res_q;
`ifdef SERIAL_CMP_MINMAX_EN
    a_cap_d     = a_cap_q;
    b_cap_d     = b_cap_q;
    msgn_d      = msgn_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          a_sh_d      = a;
          b_sh_d      = b;
          sign_diff_d = a[WIDTH-1] ^ b[WIDTH-1];
          a_neg_d     = a[WIDTH-1];
          cnt_d       = '0;
          state_d     = SCAN;
`ifdef SERIAL_CMP_MINMAX_EN
          a_cap_d     = a;
          b_cap_d     = b;
          msgn_d      = mode_signed;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      SCAN: begin
        if (!dig_eq) begin
          // Opposite signs decide signed order regardless of magnitude.
          res_d.ltu = dig_lt;
          res_d.eq  = 1'b0;
          res_d.lt  = sign_diff_q ? a_neg_q : dig_lt;
          done_d    = 1'b1;
          state_d   = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          res_d.lt  = 1'b0;
          res_d.ltu = 1'b0;
          res_d.eq  = 1'b1;
          done_d    = 1'b1;
          state_d   = IDLE;
        end else begin
          a_sh_d = a_sh_q << DIGIT;
          b_sh_d = b_sh_q << DIGIT;
          cnt_d  = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

`ifdef SERIAL_CMP_MINMAX_EN
  // Order the captured operands with the freshly computed result at done.
  always_comb begin
    min_d   = min_q;
    max_d   = max_q;
    a_first = msgn_q ? res_d.lt : res_d.ltu;
    if (done_d) begin
      if (a_first) begin
        min_d = a_cap_q;
        max_d = b_cap_q;
      end else begin
        min_d = b_cap_q;
        max_d = a_cap_q;
      end
    end else begin
      min_d = min_q;
      max_d = max_q;
    end
  end

  assign min = min_q;
  assign max = max_q;
`endif

  assign busy = (state_q == SCAN);
  assign done = done_q;
  assign lt   = res_q.lt;
  assign ltu  = res_q.ltu;
  assign eq   = res_q.eq;

endmodule
